// File: rtl/ws2812b_pkg.sv
// Shared types and timing defaults for the WS2812B frame sequencer and its NRZ bit encoder.
package ws2812b_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_STALL = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  localparam int BITS_PER_PIXEL = 24;
  // Must match the encoder's DURATION_CLK_COUNTS so trigger spacing equals one coded bit.
  localparam int DURATION_CLK_COUNTS = 62;
  localparam int DEF_LED_COUNT = 8;
  localparam int DEF_LATCH_CLKS = 14000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812b_pixel_shifter.sv
// One-word prefetch holding register feeding an MSB-first shift register with a bit counter.
module ws2812b_pixel_shifter
  import ws2812b_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      load_hold,
  input  logic                      load_direct,
  input  logic                      load_from_hold,
  input  logic                      shift,
  output logic                      msb,
  output logic                      last_bit,
  output logic                      hold_full
);

  logic [BITS_PER_PIXEL-1:0] hold_reg;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [4:0]                bit_cnt;

  always_ff @(posedge clk) begin
    if (load_hold)
      hold_reg <= pix_data;
    if (load_direct)
      shreg <= pix_data;
    else if (load_from_hold)
      shreg <= hold_reg;
    else if (shift)
      shreg <= {shreg[BITS_PER_PIXEL-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      bit_cnt   <= 5'd0;
    end else begin
      if (load_hold)
        hold_full <= 1'b1;
      else if (load_from_hold)
        hold_full <= 1'b0;
      if (load_direct || load_from_hold)
        bit_cnt <= 5'd0;
      else if (shift)
        bit_cnt <= bit_cnt + 5'd1;
    end
  end

  assign msb      = shreg[BITS_PER_PIXEL-1];
  assign last_bit = (bit_cnt == 5'(BITS_PER_PIXEL - 1));

endmodule

// File: rtl/ws2812b_frame_ctrl.sv
// Frame sequencer: pulls GRB pixels, drives trigger/bit to the NRZ encoder, then holds a latch gap.
module ws2812b_frame_ctrl
  import ws2812b_pkg::*;
#(
  parameter int BIT_CLKS   = DURATION_CLK_COUNTS,
  parameter int LED_COUNT  = DEF_LED_COUNT,
  parameter int LATCH_CLKS = DEF_LATCH_CLKS,
  localparam int IW = max2(1, $clog2(LED_COUNT)),
  localparam int CW = $clog2(LED_COUNT + 1),
  localparam int TW = $clog2(max2(BIT_CLKS, LATCH_CLKS) + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [IW-1:0]             pix_index,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underrun,
  output logic                      nrz_trigger,
  output logic                      nrz_bit
);

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic [CW-1:0] fetched;
  logic [CW-1:0] loaded;
  logic          post_reset;

  logic hs, bit_end, latch_end;
  logic start_acc, set_ur, gap_end;
  logic ld_hold, ld_direct, ld_from_hold, shift;
  logic msb, last_bit, hold_full;

  ws2812b_pixel_shifter u_shifter (
    .clk            (clk),
    .reset          (reset),
    .pix_data       (pix_data),
    .load_hold      (ld_hold),
    .load_direct    (ld_direct),
    .load_from_hold (ld_from_hold),
    .shift          (shift),
    .msb            (msb),
    .last_bit       (last_bit),
    .hold_full      (hold_full)
  );

  assign pix_ready = ((state == ST_FETCH) || (state == ST_SEND) || (state == ST_STALL))
                     && !hold_full && (fetched < CW'(LED_COUNT));
  assign hs        = pix_valid && pix_ready;
  assign bit_end   = (state == ST_SEND) && (timer == TW'(BIT_CLKS - 1));
  assign latch_end = (state == ST_LATCH) && (timer == TW'(LATCH_CLKS - 1));

  assign busy        = (state != ST_IDLE);
  assign nrz_trigger = (state == ST_SEND) && (timer == '0);
  assign nrz_bit     = (state == ST_SEND) && msb;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_LATCH;
    else
      state <= state_n;
  end

  always_comb begin
    state_n      = state;
    start_acc    = 1'b0;
    set_ur       = 1'b0;
    gap_end      = 1'b0;
    ld_hold      = 1'b0;
    ld_direct    = 1'b0;
    ld_from_hold = 1'b0;
    shift        = 1'b0;
    case (state)
      ST_IDLE: begin
        // The frame_done cycle itself must not re-arm the sequencer.
        if (start && !frame_done) begin
          state_n   = ST_FETCH;
          start_acc = 1'b1;
        end
      end
      ST_FETCH: begin
        if (hs) begin
          ld_direct = 1'b1;
          state_n   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_end) begin
          if (!last_bit)
            shift = 1'b1;
          else if (loaded == CW'(LED_COUNT))
            state_n = ST_LATCH;
          else if (hold_full)
            ld_from_hold = 1'b1;
          else if (hs)
            ld_direct = 1'b1;
          else begin
            state_n = ST_STALL;
            set_ur  = 1'b1;
          end
        end
        ld_hold = hs && !ld_direct;
      end
      ST_STALL: begin
        if (hs) begin
          ld_direct = 1'b1;
          state_n   = ST_SEND;
        end
      end
      ST_LATCH: begin
        if (latch_end) begin
          state_n = ST_IDLE;
          gap_end = 1'b1;
        end
      end
      default: state_n = ST_LATCH;
    endcase
  end

  // Shared timer: bit period in SEND, gap length in LATCH, parked at zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (((state == ST_SEND) && !bit_end) || ((state == ST_LATCH) && !latch_end))
      timer <= timer + 1'b1;
    else
      timer <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched    <= '0;
      loaded     <= '0;
      pix_index  <= '0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
      post_reset <= 1'b1;
    end else begin
      frame_done <= gap_end && !post_reset;
      if (start_acc) begin
        fetched    <= '0;
        loaded     <= '0;
        pix_index  <= '0;
        underrun   <= 1'b0;
        post_reset <= 1'b0;
      end else begin
        if (hs) begin
          fetched <= fetched + 1'b1;
          if (pix_index != IW'(LED_COUNT - 1))
            pix_index <= pix_index + 1'b1;
        end
        if (ld_direct || ld_from_hold)
          loaded <= loaded + 1'b1;
        if (set_ur)
          underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Directed bench for ws2812b_frame_ctrl: a two-pixel instance and a one-pixel instance.
module tb_ws2812b_frame_ctrl;

  localparam int BIT_CLKS = 62;
  localparam int LATCH    = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready, busy, frame_done, underrun, nrz_trigger, nrz_bit;
  logic [0:0]  pix_index;

  logic        start1 = 1'b0;
  logic [23:0] pix_data1 = 24'h0;
  logic        pix_valid1 = 1'b0;
  logic        pix_ready1, busy1, frame_done1, underrun1, nrz_trigger1, nrz_bit1;
  logic [0:0]  pix_index1;

  ws2812b_frame_ctrl #(.BIT_CLKS(BIT_CLKS), .LED_COUNT(2), .LATCH_CLKS(LATCH)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_index(pix_index), .busy(busy), .frame_done(frame_done),
    .underrun(underrun), .nrz_trigger(nrz_trigger), .nrz_bit(nrz_bit)
  );

  ws2812b_frame_ctrl #(.BIT_CLKS(BIT_CLKS), .LED_COUNT(1), .LATCH_CLKS(LATCH)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pix_data(pix_data1), .pix_valid(pix_valid1),
    .pix_ready(pix_ready1), .pix_index(pix_index1), .busy(busy1), .frame_done(frame_done1),
    .underrun(underrun1), .nrz_trigger(nrz_trigger1), .nrz_bit(nrz_bit1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Pixel source and trigger recorder for the two-pixel instance.
  logic [23:0] src_pix [2];
  int  src_block   = 9;
  bit  src_release = 1'b0;
  int  seq         = 0;
  int  src_idx     = 2;
  int  ntrig       = 0;
  int  nfd         = 0;
  int  hs_cyc      = 0;
  int  maxidx      = 0;
  int  trig_cyc [64];
  bit  trig_bit [64];

  assign pix_valid = (src_idx < 2) && !((src_idx == src_block) && !src_release);
  assign pix_data  = src_pix[(src_idx > 1) ? 1 : src_idx];

  initial begin
    int  last_seq;
    bit  will;
    last_seq = 0;
    forever begin
      @(negedge clk);
      if (seq != last_seq) begin
        last_seq = seq;
        src_idx  = 0;
        ntrig    = 0;
        nfd      = 0;
        maxidx   = 0;
      end
      if (nrz_trigger && ntrig < 64) begin
        trig_cyc[ntrig] = cyc;
        trig_bit[ntrig] = nrz_bit;
        ntrig++;
      end
      if (frame_done) nfd++;
      if (int'(pix_index) > maxidx) maxidx = int'(pix_index);
      will = pix_valid && pix_ready;
      if (will) hs_cyc = cyc;
      @(posedge clk);
      #1;
      if (will) src_idx++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_trig(input int n, input int budget);
    int k = 0;
    while (ntrig < n && k < budget) begin
      tick(1);
      k++;
    end
    if (ntrig < n) chk("trig_timeout", ntrig, n);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!frame_done && k < budget) begin
      tick(1);
      k++;
    end
    if (!frame_done) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_bits(input string tag, input logic [47:0] exp, input int gap_at);
    int bad = 0;
    int badsp = 0;
    for (int i = 0; i < 48; i++)
      if (trig_bit[i] != exp[47-i]) bad++;
    for (int i = 1; i < 48; i++)
      if (i != gap_at && (trig_cyc[i] - trig_cyc[i-1]) != BIT_CLKS) badsp++;
    chk({tag, "_bits"}, bad, 0);
    chk({tag, "_spacing"}, badsp, 0);
  endtask

  initial begin
    int n;
    int t_end;
    int bad_r;
    int bad_t;
    int nt1;
    logic [23:0] got1;

    // Reset and post-reset latch gap
    reset = 1'b1;
    tick(3);
    chk("rst_busy", busy, 1);
    chk("rst_trigger", nrz_trigger, 0);
    chk("rst_bit", nrz_bit, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_index", pix_index, 0);
    reset = 1'b0;
    n = 0;
    while (busy && n < LATCH + 50) begin
      tick(1);
      n++;
    end
    chk("post_rst_gap", n, LATCH);
    chk("post_rst_no_done", nfd, 0);
    chk("post_rst_idle1", busy1, 0);

    // Test 1: two pixels, valid always high
    src_pix[0] = 24'hA50000;
    src_pix[1] = 24'h00FF01;
    src_block  = 9;
    seq++;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t1_busy", busy, 1);
    wait_done(48 * BIT_CLKS + LATCH + 100);
    chk("t1_ntrig", ntrig, 48);
    chk_bits("t1", {24'hA50000, 24'h00FF01}, -1);
    chk("t1_done_latency", cyc - trig_cyc[47], BIT_CLKS + LATCH);
    chk("t1_underrun", underrun, 0);
    chk("t1_idle", busy, 0);
    tick(2);
    chk("t1_ndone", nfd, 1);

    // Test 2: second pixel held off 100 clk after the first word ends
    src_pix[0]  = 24'h5A0F3C;
    src_pix[1]  = 24'hC30081;
    src_block   = 1;
    src_release = 1'b0;
    seq++;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_trig(24, 30 * BIT_CLKS);
    t_end = trig_cyc[23] + BIT_CLKS - 1;
    n = 0;
    while (cyc < t_end + 100 && n < 400) begin
      tick(1);
      n++;
    end
    chk("t2_stall_ntrig", ntrig, 24);
    chk("t2_underrun", underrun, 1);
    chk("t2_stall_ready", pix_ready, 1);
    src_release = 1'b1;
    wait_done(30 * BIT_CLKS + LATCH + 100);
    chk("t2_ntrig", ntrig, 48);
    chk_bits("t2", {24'h5A0F3C, 24'hC30081}, 24);
    chk("t2_gap", trig_cyc[24] - trig_cyc[23], BIT_CLKS + 100);
    chk("t2_hs_to_trig", trig_cyc[24] - hs_cyc, 1);
    chk("t2_underrun_sticky", underrun, 1);

    // Test 5: start in the frame_done cycle is ignored, next cycle accepted
    src_block  = 9;
    src_pix[0] = 24'h800001;
    src_pix[1] = 24'h7FFFFE;
    start = 1'b1;
    tick(1);
    chk("t5_ignored_in_done", busy, 0);
    chk("t5_underrun_kept", underrun, 1);
    seq++;
    tick(1);
    start = 1'b0;
    chk("t5_accepted", busy, 1);
    chk("t5_underrun_clr", underrun, 0);
    chk("t5_index", pix_index, 0);

    // Test 3: start pulses mid-SEND and mid-LATCH are ignored
    wait_trig(10, 12 * BIT_CLKS);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t3_busy_send", busy, 1);
    wait_trig(48, 40 * BIT_CLKS);
    tick(100);
    chk("t3_in_latch", busy, 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(LATCH + 100);
    tick(3);
    chk("t3_ndone", nfd, 1);
    chk("t3_ntrig", ntrig, 48);
    chk_bits("t3", {24'h800001, 24'h7FFFFE}, -1);
    chk("t3_maxidx", maxidx, 1);
    chk("t3_idle", busy, 0);

    // Test 4: reset at bit 10 of pixel 0
    src_pix[0] = 24'hFFFFFF;
    src_pix[1] = 24'h000000;
    seq++;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_trig(11, 14 * BIT_CLKS);
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t4_trigger", nrz_trigger, 0);
    chk("t4_ready", pix_ready, 0);
    chk("t4_busy", busy, 1);
    n = 0;
    while (busy && n < LATCH + 50) begin
      tick(1);
      n++;
    end
    chk("t4_gap", n, LATCH);
    chk("t4_ntrig", ntrig, 11);
    chk("t4_no_done", nfd, 0);
    tick(2);
    chk("t4_idle", busy, 0);

    // Test 6: one-pixel instance, first pixel 500 clk late
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    bad_r = 0;
    bad_t = 0;
    for (int i = 0; i < 500; i++) begin
      if (!pix_ready1) bad_r++;
      if (nrz_trigger1) bad_t++;
      tick(1);
    end
    chk("t6_ready_fetch", bad_r, 0);
    chk("t6_no_early_trig", bad_t, 0);
    pix_data1  = 24'hF0F0F0;
    pix_valid1 = 1'b1;
    tick(1);
    pix_valid1 = 1'b0;
    chk("t6_trig_after_hs", nrz_trigger1, 1);
    chk("t6_first_bit", nrz_bit1, 1);
    chk("t6_ready_after", pix_ready1, 0);
    nt1  = 1;
    got1 = {23'h0, nrz_bit1};
    n = 0;
    while (!frame_done1 && n < 24 * BIT_CLKS + LATCH + 100) begin
      tick(1);
      n++;
      if (nrz_trigger1) begin
        got1 = {got1[22:0], nrz_bit1};
        nt1++;
      end
    end
    chk("t6_done", frame_done1, 1);
    chk("t6_ntrig", nt1, 24);
    chk("t6_word", got1, 24'hF0F0F0);
    chk("t6_underrun", underrun1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
